// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - two-stage valid/ready bitwise logic unit with result-change counter
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [2:0]       op_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_1,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] change_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             stall;
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] result;

  assign stall        = s2_valid_q & ~out_ready;
  assign in_ready     = ~s1_valid_q | ~stall;
  assign accept       = in_valid & in_ready;
  assign deliver      = s2_valid_q & out_ready;
  assign out_valid    = s2_valid_q;
  assign out_1        = out_q;
  assign change_count = cnt_q;

  always_comb begin
    result = '0;
    case (s1_op_q)
      3'b000:  result = s1_a_q & s1_b_q;
      3'b001:  result = s1_a_q | s1_b_q;
      3'b010:  result = s1_a_q ^ s1_b_q;
      3'b011:  result = ~(s1_a_q & s1_b_q);
      3'b100:  result = ~(s1_a_q | s1_b_q);
      3'b101:  result = ~(s1_a_q ^ s1_b_q);
      3'b110:  result = s1_a_q & ~s1_b_q;
      default: result = s1_a_q;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    last_d     = last_q;
    cnt_d      = cnt_q;

    // Stage 1 may refill while stage 2 is stalled as long as it is empty.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = in_1;
      s1_b_d     = in_2;
      s1_op_d    = op_sel;
    end else if (!stall) begin
      s1_valid_d = 1'b0;
    end

    if (!stall) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = result;
      end
    end

    if (deliver) begin
      last_d = out_q;
    end

    if (cnt_clear) begin
      cnt_d = '0;
    end else if (deliver && (out_q != last_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
